// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared FSM encoding, code-word constants and unit counts for the Morse transmitter
// Contents: state_e (transmit FSM states), code-word length markers, interval lengths in Morse units,
// sym_units() helper mapping a pattern bit to its mark length.
package morse_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MARK   = 3'd2,
        S_SGAP   = 3'd3,
        S_CGAP   = 3'd4,
        S_WGAP   = 3'd5
    } state_e;

    localparam logic [2:0] LEN_SPACE   = 3'd6;
    localparam logic [2:0] LEN_ETX     = 3'd7;
    localparam logic [2:0] LEN_INVALID = 3'd0;

    localparam logic [2:0] DOT_UNITS  = 3'd1;
    localparam logic [2:0] DASH_UNITS = 3'd3;
    localparam logic [2:0] SYM_GAP    = 3'd1;
    localparam logic [2:0] CHAR_GAP   = 3'd3;
    localparam logic [2:0] WORD_EXTRA = 3'd4;

    function automatic logic [2:0] sym_units(input logic is_dash);
        return is_dash ? DASH_UNITS : DOT_UNITS;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// rtl/morse_unit_timer.sv - loadable interval timer counting whole Morse units
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset
//   load_i         : start a new interval of units_i units (takes priority over counting)
//   units_i [2:0]  : interval length in units
//   expire_o       : high on the last cycle of the interval; an n-unit interval lasts n*UNIT_CYCLES cycles
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 50000,
    parameter int CNT_W       = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       load_i,
    input  logic [2:0] units_i,
    output logic       expire_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(UNIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       units_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q   <= '0;
            units_q <= '0;
        end else if (load_i) begin
            cnt_q   <= CNT_MAX;
            units_q <= units_i;
        end else if (units_q != 3'd0) begin
            // units_q parks at 0 once the interval is over, so the timer goes quiet until reloaded
            if (cnt_q == '0) begin
                cnt_q   <= CNT_MAX;
                units_q <= units_q - 3'd1;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign expire_o = (units_q == 3'd1) && (cnt_q == '0);

endmodule

// File: rtl/morse_code_transmit_ctrl.sv
// rtl/morse_code_transmit_ctrl.sv - Morse transmit sequencer: character handshake, code-table lookup, keyed output
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   in_data/in_valid  : ASCII character source; in_ready high while idle
//   rom_addr/rom_data : external code table, rom_data = {len[2:0], pattern[4:0]}
//   key_out           : carrier on; tone_out: keyed square wave (macro MORSE_TX_TONE_EN, else 0)
//   busy              : FSM not idle; done/err: one-cycle pulses for ETX / uncoded character
module morse_code_transmit_ctrl
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 50000,
    parameter int CNT_W       = 16,
    parameter int TONE_HALF   = 12500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       key_out,
    output logic       tone_out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    if (UNIT_CYCLES < 2 || TONE_HALF < 1 || CNT_W < $clog2(UNIT_CYCLES)) begin : g_bad_params
        $error("morse_code_transmit_ctrl: parameter out of range");
    end

    state_e     state_q;
    logic       rdy_q, key_q, done_q, err_q;
    logic [7:0] rom_addr_q;
    logic [4:0] pat_q;
    logic [2:0] idx_q;

    logic [2:0] rom_len;
    logic [7:0] rom_pat_ext;
    logic [2:0] first_idx;
    logic       tmr_load, tmr_expire;
    logic [2:0] tmr_units;

    assign rom_len     = rom_data[7:5];
    // zero-extended so the first-symbol lookup stays in range for every len value
    assign rom_pat_ext = {3'b000, rom_data[4:0]};
    assign first_idx   = rom_len - 3'd1;

    // Timer loads coincide with the FSM transitions below so each interval starts on its first cycle
    always_comb begin
        tmr_load  = 1'b0;
        tmr_units = SYM_GAP;
        case (state_q)
            S_LOOKUP: begin
                tmr_load  = 1'b1;
                tmr_units = (rom_len == LEN_SPACE) ? WORD_EXTRA : sym_units(rom_pat_ext[first_idx]);
            end
            S_MARK: begin
                tmr_load  = tmr_expire;
                tmr_units = (idx_q != 3'd0) ? SYM_GAP : CHAR_GAP;
            end
            S_SGAP: begin
                tmr_load  = tmr_expire;
                tmr_units = sym_units(pat_q[idx_q]);
            end
            default: ;
        endcase
    end

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .load_i  (tmr_load),
        .units_i (tmr_units),
        .expire_o(tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rdy_q      <= 1'b1;
            key_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rom_addr_q <= '0;
            pat_q      <= '0;
            idx_q      <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && rdy_q) begin
                        rom_addr_q <= in_data;
                        rdy_q      <= 1'b0;
                        state_q    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    pat_q <= rom_data[4:0];
                    idx_q <= first_idx;
                    if (rom_len == LEN_INVALID) begin
                        err_q   <= 1'b1;
                        rdy_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (rom_len == LEN_ETX) begin
                        done_q  <= 1'b1;
                        rdy_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (rom_len == LEN_SPACE) begin
                        state_q <= S_WGAP;
                    end else begin
                        key_q   <= 1'b1;
                        state_q <= S_MARK;
                    end
                end
                S_MARK: begin
                    if (tmr_expire) begin
                        key_q <= 1'b0;
                        if (idx_q != 3'd0) begin
                            idx_q   <= idx_q - 3'd1;
                            state_q <= S_SGAP;
                        end else begin
                            state_q <= S_CGAP;
                        end
                    end
                end
                S_SGAP: begin
                    if (tmr_expire) begin
                        key_q   <= 1'b1;
                        state_q <= S_MARK;
                    end
                end
                S_CGAP, S_WGAP: begin
                    if (tmr_expire) begin
                        rdy_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    key_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = rdy_q;
    assign rom_addr = rom_addr_q;
    assign key_out  = key_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;

`ifdef MORSE_TX_TONE_EN
    localparam logic [CNT_W-1:0] TONE_MAX = CNT_W'(TONE_HALF - 1);

    logic [CNT_W-1:0] tone_cnt_q;
    logic             tone_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else if (!key_q) begin
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else if (tone_cnt_q == TONE_MAX) begin
            tone_cnt_q <= '0;
            tone_q     <= ~tone_q;
        end else begin
            tone_cnt_q <= tone_cnt_q + 1'b1;
        end
    end

    // gating by key_q silences the tone on the very cycle the key drops
    assign tone_out = tone_q & key_q;
`else
    assign tone_out = 1'b0;
`endif

endmodule

// File: tb/tb_morse_code_transmit_ctrl.sv
// tb/tb_morse_code_transmit_ctrl.sv - scoreboard bench for morse_code_transmit_ctrl with a Morse-string reference model
module tb_morse_code_transmit_ctrl;

    localparam int U = 4;

    // expected per-cycle vector: {key_out, in_ready, busy, done, err, tone_out}
    localparam logic [5:0] V_BUSY_OFF = 6'b001000;
    localparam logic [5:0] V_BUSY_ON  = 6'b101000;
    localparam logic [5:0] V_IDLE     = 6'b010000;
    localparam logic [5:0] V_DONE     = 6'b010100;
    localparam logic [5:0] V_ERR      = 6'b010010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, key_out, tone_out, busy, done, err;
    logic [7:0] rom_addr, rom_data;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_q[$];
    int         len_q[$];
    logic [7:0] chr_q[$];
    bit         mon_en = 1'b0;
    bit         active = 1'b0;

    string LET[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                       "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                       "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string DIG[10] = '{"-----", ".----", "..---", "...--", "....-",
                       ".....", "-....", "--...", "---..", "----."};

    always #5 clk = ~clk;

    morse_code_transmit_ctrl #(
        .UNIT_CYCLES(U),
        .CNT_W      (4),
        .TONE_HALF  (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .key_out (key_out),
        .tone_out(tone_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    function automatic string morse_of(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A) return LET[int'(c) - 65];
        if (c >= 8'h30 && c <= 8'h39) return DIG[int'(c) - 48];
        return "";
    endfunction

    // external code table, built from the Morse strings
    function automatic logic [7:0] rom_fn(input logic [7:0] c);
        string      s;
        logic [4:0] pat;
        if (c == 8'h20) return {3'd6, 5'd0};
        if (c == 8'h03) return {3'd7, 5'd0};
        s   = morse_of(c);
        pat = '0;
        for (int i = 0; i < s.len(); i++) pat = {pat[3:0], s[i] == "-"};
        return {3'(s.len()), pat};
    endfunction

    assign rom_data = rom_fn(rom_addr);

    task automatic add(input logic [5:0] v, input int count, inout int n);
        for (int i = 0; i < count; i++) exp_q.push_back(v);
        n += count;
    endtask

    // reference: expected trace from the cycle after the accept edge through the first idle cycle
    task automatic push_expect(input logic [7:0] c);
        int    n = 0;
        string s = morse_of(c);
        add(V_BUSY_OFF, 1, n);
        if (c == 8'h03) begin
            add(V_DONE, 1, n);
        end else if (c == 8'h20) begin
            add(V_BUSY_OFF, 4 * U, n);
            add(V_IDLE, 1, n);
        end else if (s.len() == 0) begin
            add(V_ERR, 1, n);
        end else begin
            for (int i = 0; i < s.len(); i++) begin
                add(V_BUSY_ON, (s[i] == "-" ? 3 : 1) * U, n);
                add(V_BUSY_OFF, (i == s.len() - 1 ? 3 : 1) * U, n);
            end
            add(V_IDLE, 1, n);
        end
        len_q.push_back(n);
        chr_q.push_back(c);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // monitor: pops one expected trace per observed accept and compares it cycle by cycle
    initial begin
        int         cur_n = 0, idx = 0, bad = 0;
        logic [7:0] cur_c = 0;
        logic [5:0] got, exp;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (active) begin
                    got = {key_out, in_ready, busy, done, err, tone_out};
`ifdef MORSE_TX_TONE_EN
                    got[0] = 1'b0;
`endif
                    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 6'bxxxxxx;
                    if (got !== exp) begin
                        if (bad == 0)
                            $display("FAIL trace char=%h cycle=%0d got=%b expected=%b", cur_c, idx, got, exp);
                        bad++;
                    end
                    idx++;
                    if (idx == cur_n) begin
                        checks++;
                        if (bad != 0) errors++;
                        active = 1'b0;
                    end
                end
                if (in_valid && in_ready) begin
                    if (len_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_accept: data=%h with no expectation queued", in_data);
                    end else begin
                        cur_n  = len_q.pop_front();
                        cur_c  = chr_q.pop_front();
                        idx    = 0;
                        bad    = 0;
                        active = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] c, input int gap);
        int t = 0;
        repeat (gap) @(posedge clk);
        #1;
        in_data  = c;
        in_valid = 1'b1;
        push_expect(c);
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 2000);
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1 within 2000 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    initial begin
        logic [7:0] c;
        int         r, t;

        repeat (3) @(negedge clk);
        check("reset_in_ready", {7'd0, in_ready}, 8'd1);
        check("reset_key", {7'd0, key_out}, 8'd0);
        check("reset_busy", {7'd0, busy}, 8'd0);
        check("reset_done", {7'd0, done}, 8'd0);
        check("reset_err", {7'd0, err}, 8'd0);
        check("reset_tone", {7'd0, tone_out}, 8'd0);
        check("reset_rom_addr", rom_addr, 8'h00);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        send(8'h45, 1);
        send(8'h41, 2);
        send(8'h30, 0);
        send(8'h45, 3);
        send(8'h20, 0);
        send(8'h54, 0);
        send(8'h03, 1);
        send(8'h61, 2);

        for (int k = 0; k < 25; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)       c = 8'(8'h41 + $urandom_range(0, 25));
            else if (r < 7)  c = 8'(8'h30 + $urandom_range(0, 9));
            else if (r == 7) c = 8'h20;
            else if (r == 8) c = 8'h03;
            else             c = 8'(8'h61 + $urandom_range(0, 25));
            send(c, int'($urandom_range(0, 3)));
        end

        t = 0;
        while ((len_q.size() != 0 || active) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 8'(len_q.size() + int'(active)), 8'd0);
        check("drain_leftover", 8'(exp_q.size()), 8'd0);

        // reset in the middle of a dash
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        in_data  = 8'h54;
        in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 100);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_dash_key_on", {7'd0, key_out}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_key", {7'd0, key_out}, 8'd0);
        check("async_reset_busy", {7'd0, busy}, 8'd0);
        check("async_reset_ready", {7'd0, in_ready}, 8'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_ready", {7'd0, in_ready}, 8'd1);
        check("post_reset_key", {7'd0, key_out}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
